// File: rtl/mem_byte_ctrl_if.sv
// MEM-stage data-memory request port: requester (master) drives the request,
// the byte controller (slave) returns load data and the stall request.
interface mem_byte_ctrl_if;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        stall_req_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    input  mem_rdata_o, stall_req_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    output mem_rdata_o, stall_req_o
  );
endinterface

// File: rtl/mem_byte_ctrl.sv
// Serves 32-bit MEM-stage requests over an 8-bit synchronous RAM, one byte per cycle.
// Optional one-word read buffer: define MEM_BYTE_CTRL_RDBUF_EN.

// One load-data byte lane: shadow capture during READ, published on the final READ cycle.
module mem_byte_lane #(
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic             fin,
  input  logic [VEC_W-1:0] din,
  output logic [VEC_W-1:0] dout
);
  logic [VEC_W-1:0] shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      dout   <= '0;
    end else begin
      if (cap) shadow <= din;
      // the top lane arrives on the same edge it is published
      if (fin) dout <= cap ? din : shadow;
    end
  end
endmodule

module mem_byte_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  mem_byte_ctrl_if.slave    mem,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_din_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_dout_i
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int TAG_W     = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  typedef struct packed {
    logic [TAG_W-1:0]                  tag;
    logic [NUM_LANES-1:0]              sel;
    logic [NUM_LANES-1:0][VEC_W-1:0]   wdata;
  } req_t;

  state_t                          state;
  logic [2:0]                      cnt;
  req_t                            req, req_in;
  logic [NUM_LANES-1:0]            pend;
  logic [ADDR_W-1:0]               addr_q;
  logic [VEC_W-1:0]                din_q;
  logic                            wr_q;
  logic                            hit;
  logic [NUM_LANES-1:0]            wr_mask, wr_rest;
  logic [1:0]                      wr_lane;
  logic [NUM_LANES-1:0]            lane_cap;
  logic                            rd_fin;
  logic [NUM_LANES-1:0][VEC_W-1:0] rd_lane;
  logic                            unused_addr;

  function automatic logic [1:0] first_lane(input logic [NUM_LANES-1:0] m);
    first_lane = 2'd0;
    for (int i = NUM_LANES-1; i >= 0; i--)
      if (m[i]) first_lane = 2'(i);
  endfunction

  assign req_in.tag   = mem.mem_addr_i[ADDR_W-1:2];
  assign req_in.sel   = mem.mem_sel_i;
  assign req_in.wdata = mem.mem_wdata_i;

  // lane index always stays in [1:0], so wb+lane never carries out of the word
  assign wr_mask = (state == IDLE) ? mem.mem_sel_i : pend;
  assign wr_lane = first_lane(wr_mask);
  assign wr_rest = wr_mask & ~(4'b0001 << wr_lane);

  assign unused_addr = ^{mem.mem_addr_i[31:ADDR_W], mem.mem_addr_i[1:0]};

`ifdef MEM_BYTE_CTRL_RDBUF_EN
  logic             buf_vld;
  logic [TAG_W-1:0] buf_tag;

  // mem_rdata_o only changes on completed loads, so it doubles as the buffer data
  assign hit = buf_vld && (buf_tag == req_in.tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld <= 1'b0;
      buf_tag <= '0;
    end else if (state == IDLE && mem.mem_ce_i) begin
      if (mem.mem_we_i && buf_tag == req_in.tag) buf_vld <= 1'b0;
    end else if (rd_fin) begin
      buf_vld <= 1'b1;
      buf_tag <= req.tag;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      req    <= '0;
      pend   <= '0;
      addr_q <= '0;
      din_q  <= '0;
      wr_q   <= 1'b0;
    end else begin
      wr_q  <= 1'b0;
      din_q <= '0;
      case (state)
        IDLE: if (mem.mem_ce_i) begin
          req <= req_in;
          cnt <= '0;
          if (!mem.mem_we_i) begin
            if (hit) state <= DONE;
            else begin
              state  <= READ;
              addr_q <= {req_in.tag, 2'b00};
            end
          end else if (mem.mem_sel_i == '0) begin
            state <= DONE;
          end else begin
            state  <= WRITE;
            addr_q <= {req_in.tag, wr_lane};
            din_q  <= req_in.wdata[wr_lane];
            wr_q   <= 1'b1;
            pend   <= wr_rest;
          end
        end
        READ: begin
          cnt <= cnt + 3'd1;
          if (cnt < 3'd3) addr_q <= {req.tag, cnt[1:0] + 2'd1};
          if (cnt == 3'd4) state <= DONE;
        end
        WRITE: begin
          if (pend == '0) state <= DONE;
          else begin
            addr_q <= {req.tag, wr_lane};
            din_q  <= req.wdata[wr_lane];
            wr_q   <= 1'b1;
            pend   <= wr_rest;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_fin = (state == READ) && (cnt == 3'd4);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_cap[g] = (state == READ) && (cnt == 3'(g + 1));
    mem_byte_lane #(.VEC_W(VEC_W)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .cap  (lane_cap[g]),
      .fin  (rd_fin),
      .din  (ram_dout_i),
      .dout (rd_lane[g])
    );
  end

  assign mem.mem_rdata_o = rd_lane;
  assign mem.stall_req_o = mem.mem_ce_i && (state != DONE) && !rst;
  assign ram_addr_o      = addr_q;
  assign ram_din_o       = din_q;
  assign ram_wr_o        = wr_q && !rst;
endmodule
